traffic_phase_controller: RTL
=============================

Name: traffic_phase_controller

Overview:
- Consumer end of the second-counter tick interface. Takes the one-cycle-per-second `last` pulse from the second counter as `sec_tick`.
- Sequences a two-way intersection through fixed-duration light phases.
- Runs a loadable down-counter of seconds remaining, with its own `last`/`pre_last` flags, for the countdown display and downstream logic.
- Sits between the second counter and the lamp/7-segment drivers.

Parameters:
pMAX_VAL, 99, largest legal phase duration in seconds; sets count width to $clog2(pMAX_VAL+1)
pGREEN_SEC, 25, green duration per direction (1..pMAX_VAL)
pYELLOW_SEC, 3, yellow duration per direction (1..pMAX_VAL)
pALLRED_SEC, 2, all-red clearance duration (1..pMAX_VAL)
pPED_CUT, 5, green seconds left after a pedestrian request truncates green (1..pGREEN_SEC)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  tick qualifier; sec_tick is ignored while en=0
sec_tick  input  1  one-cycle pulse per second (second counter last)
ped_req  input  1  pedestrian request pulse or level; latched internally
ns_light  output  3  {red,yellow,green} one-hot, north-south
ew_light  output  3  {red,yellow,green} one-hot, east-west
count  output  $clog2(pMAX_VAL+1)  seconds remaining in current phase (duration..1)
last  output  1  combinational: count==1
pre_last  output  1  combinational: count==2
phase  output  3  state encoding, for debug and verification

Behaviour:
- States and encodings, in order: ALLRED_A=0, NS_GREEN=1, NS_YELLOW=2, ALLRED_B=3, EW_GREEN=4, EW_YELLOW=5, then back to ALLRED_A. Encodings 6 and 7 are illegal and recover to ALLRED_A on the next clk.
- Lights:
  - ALLRED_A, ALLRED_B: both 3'b100.
  - NS_GREEN: ns=3'b001, ew=3'b100.
  - NS_YELLOW: ns=3'b010, ew=3'b100.
  - EW_GREEN: ew=3'b001, ns=3'b100.
  - EW_YELLOW: ew=3'b010, ns=3'b100.
  - Lights are decoded from the state register only, so they carry no extra latency.
- Reset (async, asserted): phase=ALLRED_A, count=pALLRED_SEC, ped_pend=0, both lights red. Reset mid-phase aborts immediately with no yellow; lights go red asynchronously.
- Valid tick: sec_tick=1 && en=1, sampled on rising clk. No valid tick means all state holds.
- On a valid tick:
  - if count==1: advance to the next state and load count with that state's duration (same edge).
  - else if state is NS_GREEN or EW_GREEN, ped_pend=1 and count>pPED_CUT: count <= pPED_CUT.
  - else: count <= count-1.
- Phase length is exactly duration valid ticks. A duration of 1 gives last=1 for the whole phase and pre_last=0 throughout.
- ped_pend:
  - Set on any clk with ped_req=1.
  - Cleared on the tick that enters ALLRED_A or ALLRED_B.
  - If ped_req=1 on that same clk, set wins and ped_pend stays 1.
  - The truncation check uses the registered ped_pend, not the raw input. A request therefore affects count on the first valid tick after the clk that latches it.
  - A request while count<=pPED_CUT, or outside green, has no effect other than being held.
- count never underflows and never takes the value 0 after reset.
- en=0 freezes count, phase and lights. It does not block ped_req latching.

Test Plan:
1. Reset, then en=1 with a tick every 4 clks → phase 0 (count 2,1), then 1 (count 25..1), 2 (3..1), 3 (2..1), 4 (25..1), 5 (3..1), back to 0. Lights match each state. Total 60 ticks per cycle.
2. Check last/pre_last in NS_GREEN → pre_last=1 only at count==2, last=1 only at count==1. Both flags are 0 at count==25.
3. ped_req pulse at NS_GREEN count=20 → next tick count=5, then 4..1, then NS_YELLOW with count=3. A second ped_req at count=3 in EW_GREEN of the following cycle has no visible effect.
4. en=0 for 10 ticks at EW_YELLOW count=2 → count, phase and lights all unchanged. Re-enabling resumes at count=2.
5. Assert rst asynchronously mid-NS_GREEN at count=12 → same cycle both lights 3'b100, phase=0, count=2, ped_pend cleared. The ped_pend clear is visible as no truncation in the next green.
6. Parameter override pYELLOW_SEC=1 → NS_YELLOW lasts 1 tick, with last=1 and pre_last=0 throughout. sec_tick arriving together with the entering ped_req at an ALLRED transition → ped_pend remains 1 and the next green truncates to 5.

Source files
------------

// File: rtl/traffic_phase_controller.sv
// Two-way intersection phase sequencer driven by a 1 Hz tick.
// Keeps a loadable seconds-remaining counter and latches pedestrian requests.
module traffic_phase_controller #(
    parameter int pMAX_VAL    = 99,
    parameter int pGREEN_SEC  = 25,
    parameter int pYELLOW_SEC = 3,
    parameter int pALLRED_SEC = 2,
    parameter int pPED_CUT    = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           sec_tick,
    input  logic                           ped_req,
    output logic [2:0]                     ns_light,
    output logic [2:0]                     ew_light,
    output logic [$clog2(pMAX_VAL+1)-1:0]  count,
    output logic                           last,
    output logic                           pre_last,
    output logic [2:0]                     phase
);

    localparam int CW = $clog2(pMAX_VAL + 1);

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    state_t          state_q, state_d, nxt;
    logic [CW-1:0]   count_q, count_d;
    logic            ped_q, ped_d;
    logic            tick;
    logic            green;

    function automatic logic [CW-1:0] dur(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   dur = CW'(pGREEN_SEC);
            NS_YELLOW, EW_YELLOW: dur = CW'(pYELLOW_SEC);
            default:              dur = CW'(pALLRED_SEC);
        endcase
    endfunction

    // Next phase, counter reload/decrement/truncation and request latch.
    always_comb begin
        tick    = sec_tick & en;
        green   = (state_q == NS_GREEN) || (state_q == EW_GREEN);
        state_d = state_q;
        count_d = count_q;
        ped_d   = ped_q | ped_req;
        nxt     = ALLRED_A;
        case (state_q)
            ALLRED_A:  nxt = NS_GREEN;
            NS_GREEN:  nxt = NS_YELLOW;
            NS_YELLOW: nxt = ALLRED_B;
            ALLRED_B:  nxt = EW_GREEN;
            EW_GREEN:  nxt = EW_YELLOW;
            default:   nxt = ALLRED_A;
        endcase
        if (state_q > EW_YELLOW) begin
            // Corrupted encoding: fall back to a safe all-red phase.
            state_d = ALLRED_A;
            count_d = CW'(pALLRED_SEC);
            ped_d   = ped_req;
        end else if (tick) begin
            if (count_q == CW'(1)) begin
                state_d = nxt;
                count_d = dur(nxt);
                if (nxt == ALLRED_A || nxt == ALLRED_B) begin
                    ped_d = ped_req;
                end
            end else if (green && ped_q && count_q > CW'(pPED_CUT)) begin
                count_d = CW'(pPED_CUT);
            end else begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Phase, counter and pending-request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ALLRED_A;
            count_q <= CW'(pALLRED_SEC);
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ped_q   <= ped_d;
        end
    end

    // Lamp decode straight from the phase register, so reset reds are immediate.
    always_comb begin
        ns_light = RED;
        ew_light = RED;
        case (state_q)
            NS_GREEN:  ns_light = GRN;
            NS_YELLOW: ns_light = YEL;
            EW_GREEN:  ew_light = GRN;
            EW_YELLOW: ew_light = YEL;
            default: begin
                ns_light = RED;
                ew_light = RED;
            end
        endcase
    end

    assign count    = count_q;
    assign last     = (count_q == CW'(1));
    assign pre_last = (count_q == CW'(2));
    assign phase    = state_q;

endmodule
